// File: rtl/reg_file_8x16_onehot_pkg.sv
// Shared sizing constants for the 16-bit MIPS register file, its write decoder and ALU operand stage.
package reg_file_8x16_onehot_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;
endpackage

// File: rtl/reg_file_8x16_onehot_onehot_chk.sv
// Classifies a select vector as empty, one-hot or multi-hot; purely combinational.
module onehot_chk #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec,
  output logic         is_one,
  output logic         is_zero,
  output logic         is_multi
);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

  assign is_zero  = (cnt == CW'(0));
  assign is_one   = (cnt == CW'(1));
  assign is_multi = (cnt > CW'(1));
endmodule

// File: rtl/reg_file_8x16_onehot.sv
// 8x16 register file: one-hot write select, two registered read ports with write-first bypass,
// R0 hardwired to zero, sticky flag for multi-hot write selects.
module reg_file_8x16_onehot
  import reg_file_8x16_onehot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [NREG-1:0]   wsel,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              wr_err
);
  logic              sel_one;
  logic              sel_zero;
  logic              sel_multi;
  logic              valid_wr;
  logic [DATA_W-1:0] reg_q [NREG];

  onehot_chk #(.N(NREG)) u_chk (
    .vec      (wsel),
    .is_one   (sel_one),
    .is_zero  (sel_zero),
    .is_multi (sel_multi)
  );

  assign valid_wr = we & sel_one;

  // R0 is a constant, not a flop; writes aimed at it simply have nowhere to land.
  assign reg_q[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (valid_wr && wsel[i]) begin
        q <= wdata;
      end
    end
    assign reg_q[i] = q;
  end

  // Write-first: a read of the register being written this edge returns the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= (ra == REG_ZERO) ? '0 : (valid_wr && wsel[ra]) ? wdata : reg_q[ra];
      rdata_b <= (rb == REG_ZERO) ? '0 : (valid_wr && wsel[rb]) ? wdata : reg_q[rb];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (we && sel_multi) begin
      wr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file_8x16_onehot.sv
// Self-checking bench for reg_file_8x16_onehot: reference model feeds an expected queue
// of {wr_err, rdata_a, rdata_b} that each scenario pops and compares after every edge.
module tb_reg_file_8x16_onehot;
  localparam int W = 33;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [7:0]  wsel;
  logic [15:0] wdata;
  logic        re;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        wr_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [15:0]  m_regs [8];
  logic [15:0]  m_a;
  logic [15:0]  m_b;
  logic         m_err;

  reg_file_8x16_onehot dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wsel    (wsel),
    .wdata   (wdata),
    .re      (re),
    .ra      (ra),
    .rb      (rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .wr_err  (wr_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_a = '0;
    m_b = '0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic i_we, input logic [7:0] i_wsel,
                             input logic [15:0] i_wdata, input logic i_re,
                             input logic [2:0] i_ra, input logic [2:0] i_rb);
    logic valid;
    we = i_we; wsel = i_wsel; wdata = i_wdata; re = i_re; ra = i_ra; rb = i_rb;
    valid = i_we && ($countones(i_wsel) == 1);
    if (i_re) begin
      m_a = (i_ra == 3'd0) ? 16'h0 : (valid && i_wsel[i_ra]) ? i_wdata : m_regs[i_ra];
      m_b = (i_rb == 3'd0) ? 16'h0 : (valid && i_wsel[i_rb]) ? i_wdata : m_regs[i_rb];
    end
    if (valid) begin
      for (int i = 1; i < 8; i++) if (i_wsel[i]) m_regs[i] = i_wdata;
    end
    if (i_we && ($countones(i_wsel) > 1)) m_err = 1'b1;
    exp_q.push_back({m_err, m_a, m_b});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wsel = '0; wdata = '0; re = 1'b0; ra = '0; rb = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] exp;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== 33'h0) begin
      errors++;
      $display("FAIL reset_initial: got err=%0b a=%h b=%h required all zero", wr_err, rdata_a, rdata_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 8'h02, 16'h1111, 1'b0, 3'd0, 3'd0);
    drive_cycle(1'b1, 8'h80, 16'h7777, 1'b1, 3'd1, 3'd7);
    drive_cycle(1'b1, 8'h03, 16'hDEAD, 1'b0, 3'd0, 3'd0);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    // mid-write asynchronous reset
    we = 1'b1; wsel = 8'h10; wdata = 16'hCAFE; re = 1'b1; ra = 3'd4; rb = 3'd7;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== 33'h0) begin
      errors++;
      $display("FAIL reset_async: got err=%0b a=%h b=%h required all zero", wr_err, rdata_a, rdata_b);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      drive_cycle(1'b0, 8'h00, 16'h0, 1'b1, 3'(r), 3'(7 - r));
      exp = exp_q.pop_front();
      checks++;
      if ({wr_err, rdata_a, rdata_b} !== exp || rdata_a !== 16'h0) begin
        errors++;
        $display("FAIL reset_readback r%0d: got %h required %h", r, {wr_err, rdata_a, rdata_b}, exp);
      end
    end
  endtask

  task automatic test_write_read();
    logic [W-1:0] exp;
    drive_cycle(1'b1, 8'h08, 16'hBEEF, 1'b0, 3'd0, 3'd0);
    void'(exp_q.pop_front());
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b1, 3'd3, 3'd3);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp || rdata_a !== 16'hBEEF || rdata_b !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_read: got a=%h b=%h err=%0b required a=BEEF b=BEEF err=0", rdata_a, rdata_b, wr_err);
    end
  endtask

  task automatic test_r0();
    logic [W-1:0] exp;
    drive_cycle(1'b1, 8'h01, 16'hFFFF, 1'b0, 3'd0, 3'd0);
    void'(exp_q.pop_front());
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b1, 3'd0, 3'd3);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp || rdata_a !== 16'h0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL r0_write: got a=%h err=%0b required a=0000 err=0", rdata_a, wr_err);
    end
    // same-edge write to R0 with read of R0 must not bypass
    drive_cycle(1'b1, 8'h01, 16'hABCD, 1'b1, 3'd0, 3'd0);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp || rdata_a !== 16'h0) begin
      errors++;
      $display("FAIL r0_bypass: got a=%h b=%h required 0000", rdata_a, rdata_b);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] exp;
    drive_cycle(1'b1, 8'h20, 16'h0F0F, 1'b0, 3'd0, 3'd0);
    void'(exp_q.pop_front());
    drive_cycle(1'b1, 8'h20, 16'h1234, 1'b1, 3'd5, 3'd3);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp || rdata_a !== 16'h1234) begin
      errors++;
      $display("FAIL bypass: got a=%h b=%h required a=1234 b=%h", rdata_a, rdata_b, exp[15:0]);
    end
  endtask

  task automatic test_hold_gating();
    logic [W-1:0] exp;
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b1, 3'd3, 3'd5);
    void'(exp_q.pop_front());
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 8'h08, 16'h4000 + 16'(c), 1'b0, 3'(c + 1), 3'(6 - c));
      exp = exp_q.pop_front();
      checks++;
      if ({wr_err, rdata_a, rdata_b} !== exp || rdata_a !== 16'hBEEF) begin
        errors++;
        $display("FAIL hold c%0d: got a=%h b=%h required a=BEEF b=%h", c, rdata_a, rdata_b, exp[15:0]);
      end
    end
    drive_cycle(1'b1, 8'h00, 16'h9999, 1'b0, 3'd0, 3'd0);
    void'(exp_q.pop_front());
    for (int r = 1; r < 8; r++) begin
      drive_cycle(1'b0, 8'h00, 16'h0, 1'b1, 3'(r), 3'(r));
      exp = exp_q.pop_front();
      checks++;
      if ({wr_err, rdata_a, rdata_b} !== exp || wr_err !== 1'b0) begin
        errors++;
        $display("FAIL zero_sel r%0d: got %h required %h", r, {wr_err, rdata_a, rdata_b}, exp);
      end
    end
  endtask

  task automatic test_multi_hot();
    logic [W-1:0] exp;
    drive_cycle(1'b1, 8'h04, 16'h00AA, 1'b0, 3'd0, 3'd0);
    void'(exp_q.pop_front());
    drive_cycle(1'b1, 8'h06, 16'h5555, 1'b1, 3'd1, 3'd2);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp || {wr_err, rdata_a, rdata_b} !== {1'b1, 16'h0000, 16'h00AA}) begin
      errors++;
      $display("FAIL multi_hot_same: got err=%0b a=%h b=%h required err=1 a=0000 b=00AA", wr_err, rdata_a, rdata_b);
    end
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b1, 3'd1, 3'd2);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp || {wr_err, rdata_a, rdata_b} !== {1'b1, 16'h0000, 16'h00AA}) begin
      errors++;
      $display("FAIL multi_hot_read: got err=%0b a=%h b=%h required err=1 a=0000 b=00AA", wr_err, rdata_a, rdata_b);
    end
    drive_cycle(1'b1, 8'h40, 16'h6666, 1'b1, 3'd6, 3'd2);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp || wr_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky_err: got %h required %h", {wr_err, rdata_a, rdata_b}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    logic [7:0]   s;
    for (int c = 0; c < 60; c++) begin
      case ($urandom_range(0, 9))
        0:       s = 8'h00;
        1:       s = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
        default: s = 8'(1 << $urandom_range(0, 7));
      endcase
      drive_cycle(1'($urandom_range(0, 1)), s, 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      exp = exp_q.pop_front();
      checks++;
      if ({wr_err, rdata_a, rdata_b} !== exp) begin
        errors++;
        $display("FAIL back_to_back c%0d: got %h required %h", c, {wr_err, rdata_a, rdata_b}, exp);
      end
    end
  endtask

  task automatic test_err_clear();
    logic [W-1:0] exp;
    drive_cycle(1'b1, 8'hFF, 16'h1, 1'b0, 3'd0, 3'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%0b required 0", wr_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b0, 8'h00, 16'h0, 1'b1, 3'd5, 3'd3);
    exp = exp_q.pop_front();
    checks++;
    if ({wr_err, rdata_a, rdata_b} !== exp) begin
      errors++;
      $display("FAIL post_reset_read: got %h required %h", {wr_err, rdata_a, rdata_b}, exp);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_hold_gating();
    test_multi_hot();
    test_back_to_back();
    test_err_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
